// File: rtl/gpio_cond_pkg.sv
// Shared constants and sizing helpers for the gpio_conditioner input path.
// Optional build macro GPIO_COND_FALL_EVT_EN is consumed by gpio_cond_channel.
package gpio_cond_pkg;

    localparam int DEF_CLK_PERIOD_NS = 20;
    localparam int DEF_DEBOUNCE_NS   = 30_000_000;

    // Number of stable clocks required before the debounced level follows the input.
    function automatic int calc_deb_cnt(input int debounce_ns, input int clk_period_ns);
        int cnt;
        cnt = debounce_ns / clk_period_ns;
        return (cnt < 1) ? 1 : cnt;
    endfunction

    function automatic int calc_cnt_w(input int deb_cnt);
        return (deb_cnt < 1) ? 1 : $clog2(deb_cnt + 1);
    endfunction

endpackage

// File: rtl/gpio_cond_channel.sv
// One conditioner bit: synchroniser, debounce counter, edge pulses and sticky event.
// With GPIO_COND_FALL_EVT_EN defined, falling edges also set the event flag.
module gpio_cond_channel
    import gpio_cond_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   CLK_PERIOD_NS = DEF_CLK_PERIOD_NS,
    parameter int   DEBOUNCE_NS   = DEF_DEBOUNCE_NS,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic sig_i,
    input  logic evt_clr,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_o
);

    localparam int DEB_CNT = calc_deb_cnt(DEBOUNCE_NS, CLK_PERIOD_NS);
    localparam int CNT_W   = calc_cnt_w(DEB_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   sig_q, sig_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   evt_q, evt_d;
    logic                   evt_set;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The synchroniser always runs; enable only gates the debounce counter.
    always_comb begin
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_s == sig_q) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                sig_d  = sync_s;
                cnt_d  = '0;
                rise_d = sync_s;
                fall_d = ~sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef GPIO_COND_FALL_EVT_EN
    assign evt_set = rise_q | fall_q;
`else
    assign evt_set = rise_q;
`endif

    // Set has priority over a simultaneous write-1-to-clear.
    assign evt_d = evt_set | (evt_q & ~evt_clr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
            sig_q  <= RESET_BIT;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sig_q  <= sig_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign sig_o  = sig_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign evt_o  = evt_q;

endmodule

// File: rtl/gpio_conditioner.sv
// N-channel input conditioner: per-pin channels plus a masked, registered interrupt flag.
// Build option GPIO_COND_FALL_EVT_EN makes falling edges latch events too.
module gpio_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int              N_CH          = 8,
    parameter int              SYNC_STAGES   = 2,
    parameter int              CLK_PERIOD_NS = DEF_CLK_PERIOD_NS,
    parameter int              DEBOUNCE_NS   = DEF_DEBOUNCE_NS,
    parameter logic [N_CH-1:0] RESET_VAL     = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic [N_CH-1:0] sig_i,
    input  logic [N_CH-1:0] evt_mask,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] sig_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] evt_o,
    output logic            irq_o
);

    logic irq_q, irq_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        gpio_cond_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .CLK_PERIOD_NS (CLK_PERIOD_NS),
            .DEBOUNCE_NS   (DEBOUNCE_NS),
            .RESET_BIT     (RESET_VAL[g])
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .enable  (enable),
            .sig_i   (sig_i[g]),
            .evt_clr (evt_clr[g]),
            .sig_o   (sig_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g]),
            .evt_o   (evt_o[g])
        );
    end

    assign irq_d = |(evt_o & evt_mask);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_gpio_conditioner.sv
// Self-checking bench for gpio_conditioner (4 channels, 5-clock debounce, 2-stage sync).
// A sample-history reference model tracks every clock and is compared in the random test.
module tb_gpio_conditioner;

    localparam int N      = 4;
    localparam int SYNC   = 2;
    localparam int DEB    = 5;   // 100 ns / 20 ns
    localparam int LAT    = SYNC + DEB;

    logic         clk;
    logic         resetn;
    logic         enable;
    logic [N-1:0] sig_i;
    logic [N-1:0] evt_mask;
    logic [N-1:0] evt_clr;
    logic [N-1:0] sig_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic [N-1:0] evt_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_out, m_rise, m_fall, m_evt;
    logic         m_irq;
    int           m_run[N];

    gpio_conditioner #(
        .N_CH          (N),
        .SYNC_STAGES   (SYNC),
        .CLK_PERIOD_NS (20),
        .DEBOUNCE_NS   (100),
        .RESET_VAL     (4'b0000)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .sig_i    (sig_i),
        .evt_mask (evt_mask),
        .evt_clr  (evt_clr),
        .sig_o    (sig_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .evt_o    (evt_o),
        .irq_o    (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_evt  = '0;
        m_irq  = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // Debounced level follows the input once it has differed for DEB enabled clocks in a row,
    // where the input seen is the raw sample from SYNC clocks earlier.
    task automatic model_step();
        logic [N-1:0] s, nr, nf, evt_n;
        if (!resetn) return;
        s = m_hist.pop_front();
        m_hist.push_back(sig_i);
        nr = '0;
        nf = '0;
        for (int c = 0; c < N; c++) begin
            if (s[c] == m_out[c]) begin
                m_run[c] = 0;
            end else if (enable) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == DEB) begin
                    m_out[c] = s[c];
                    m_run[c] = 0;
                    nr[c] = s[c];
                    nf[c] = !s[c];
                end
            end
        end
`ifdef GPIO_COND_FALL_EVT_EN
        evt_n = (m_evt & ~evt_clr) | m_rise | m_fall;
`else
        evt_n = (m_evt & ~evt_clr) | m_rise;
`endif
        m_irq  = |(m_evt & evt_mask);
        m_evt  = evt_n;
        m_rise = nr;
        m_fall = nf;
    endtask

    // one clock: inputs are stable across the posedge, outputs are observed at the negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        enable   = 1'b1;
        sig_i    = '0;
        evt_mask = '0;
        evt_clr  = '0;
        model_reset();
        #25;
        checks++; if (sig_o !== 4'b0000) begin errors++; $display("FAIL reset_sig_o got=%b exp=0000", sig_o); end
        checks++; if (rise_o !== 4'b0000) begin errors++; $display("FAIL reset_rise_o got=%b exp=0000", rise_o); end
        checks++; if (fall_o !== 4'b0000) begin errors++; $display("FAIL reset_fall_o got=%b exp=0000", fall_o); end
        checks++; if (evt_o !== 4'b0000) begin errors++; $display("FAIL reset_evt_o got=%b exp=0000", evt_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq_o got=%b exp=0", irq_o); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_latency();
        int seen;
        seen = -1;
        sig_i[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (sig_o[0] === 1'b1) begin seen = n; break; end
        end
        checks++; if (seen != LAT) begin errors++; $display("FAIL latency_ch0 got=%0d exp=%0d", seen, LAT); end
        checks++; if (rise_o !== 4'b0001) begin errors++; $display("FAIL rise_pulse_ch0 got=%b exp=0001", rise_o); end
        checks++; if (fall_o !== 4'b0000) begin errors++; $display("FAIL no_fall_ch0 got=%b exp=0000", fall_o); end
        tick();
        checks++; if (rise_o[0] !== 1'b0) begin errors++; $display("FAIL rise_one_cycle got=%b exp=0", rise_o[0]); end
        checks++; if (evt_o[0] !== 1'b1) begin errors++; $display("FAIL evt_set_ch0 got=%b exp=1", evt_o[0]); end
        tick();
        checks++; if (evt_o[0] !== 1'b1) begin errors++; $display("FAIL evt_sticky_ch0 got=%b exp=1", evt_o[0]); end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        sig_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sig_i[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sig_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || evt_o[1] !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_ch1 bad_cycles got=%0d exp=0", bad); end
        // a fresh clean edge must still need the full latency, proving the count restarted
        sig_i[1] = 1'b1;
        for (int i = 0; i < LAT - 1; i++) tick();
        checks++; if (sig_o[1] !== 1'b0) begin errors++; $display("FAIL glitch_restart_early got=%b exp=0", sig_o[1]); end
        tick();
        checks++; if (sig_o[1] !== 1'b1) begin errors++; $display("FAIL glitch_restart_late got=%b exp=1", sig_o[1]); end
        sig_i[1] = 1'b0;
        for (int i = 0; i < LAT + 2; i++) tick();
        evt_clr = 4'b0010;
        tick();
        evt_clr = '0;
        tick();
    endtask

    task automatic test_enable_pause();
        int seen;
        seen = -1;
        sig_i[2] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5)  enable = 1'b0;
            if (n == 15) enable = 1'b1;
            tick();
            if (sig_o[2] === 1'b1) begin seen = n; break; end
        end
        enable = 1'b1;
        checks++; if (seen != LAT + 10) begin errors++; $display("FAIL enable_pause_ch2 got=%0d exp=%0d", seen, LAT + 10); end
    endtask

    task automatic test_evt_clear();
        int ok;
        ok = 0;
        sig_i[0] = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); if (fall_o[0] === 1'b1) ok = 1; end
        checks++; if (ok != 1) begin errors++; $display("FAIL fall_ch0 timeout got=%0d exp=1", ok); end
        sig_i[0] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); if (rise_o[0] === 1'b1) ok = 1; end
        checks++; if (ok != 1) begin errors++; $display("FAIL rise_ch0 timeout got=%0d exp=1", ok); end
        evt_clr = 4'b0001;
        tick();
        evt_clr = '0;
        checks++; if (evt_o[0] !== 1'b1) begin errors++; $display("FAIL set_wins_ch0 got=%b exp=1", evt_o[0]); end
        tick();
        evt_clr = 4'b0001;
        tick();
        evt_clr = '0;
        checks++; if (evt_o[0] !== 1'b0) begin errors++; $display("FAIL clear_ch0 got=%b exp=0", evt_o[0]); end
        evt_clr = 4'b0001;
        tick();
        evt_clr = '0;
        checks++; if (evt_o[0] !== 1'b0) begin errors++; $display("FAIL clear_idle_ch0 got=%b exp=0", evt_o[0]); end
    endtask

    task automatic test_irq_mask();
        int ok;
        sig_i[0] = 1'b0;
        for (int i = 0; i < LAT + 2; i++) tick();
        evt_clr = 4'b0001;
        tick();
        evt_clr = '0;
        sig_i[0] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); if (rise_o[0] === 1'b1) ok = 1; end
        tick();
        tick();
        checks++; if (evt_o !== 4'b0101) begin errors++; $display("FAIL evt_pattern got=%b exp=0101", evt_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_masked_off got=%b exp=0", irq_o); end
        evt_mask = 4'b0100;
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_mask_0100 got=%b exp=1", irq_o); end
        evt_mask = 4'b1010;
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_mask_1010 got=%b exp=0", irq_o); end
        evt_mask = '0;
    endtask

    task automatic test_reset_midcount();
        int bad, ok;
        logic exp3;
        sig_i[3] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #5;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (sig_o !== 4'b0000) begin errors++; $display("FAIL async_reset_sig_o got=%b exp=0000", sig_o); end
        checks++; if (evt_o !== 4'b0000) begin errors++; $display("FAIL async_reset_evt_o got=%b exp=0000", evt_o); end
        checks++; if ({rise_o, fall_o, irq_o} !== 9'b0) begin errors++; $display("FAIL async_reset_pulses got=%b exp=0", {rise_o, fall_o, irq_o}); end
        sig_i = '0;
        @(negedge clk);
        tick();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ({sig_o, rise_o, fall_o, evt_o, irq_o} !== 17'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL post_reset_quiet bad_cycles got=%0d exp=0", bad); end
        sig_i[3] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); if (rise_o[3] === 1'b1) ok = 1; end
        tick();
        tick();
        evt_clr = 4'b1000;
        tick();
        evt_clr = '0;
        sig_i[3] = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); if (fall_o[3] === 1'b1) ok = 1; end
        checks++; if (ok != 1) begin errors++; $display("FAIL fall_ch3 timeout got=%0d exp=1", ok); end
        tick();
`ifdef GPIO_COND_FALL_EVT_EN
        exp3 = 1'b1;
`else
        exp3 = 1'b0;
`endif
        checks++; if (evt_o[3] !== exp3) begin errors++; $display("FAIL fall_evt_ch3 got=%b exp=%b", evt_o[3], exp3); end
    endtask

    task automatic test_random();
        int hold[N];
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    sig_i[c] = 1'($urandom_range(0, 1));
                    hold[c]  = $urandom_range(1, 10);
                end else begin
                    hold[c]--;
                end
            end
            enable  = ($urandom_range(0, 9) != 0);
            evt_clr = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            if (cyc % 16 == 0) evt_mask = 4'($urandom_range(0, 15));
            if (cyc == 300) begin
                #3;
                resetn = 1'b0;
                model_reset();
                tick();
                resetn = 1'b1;
            end else begin
                tick();
            end
            checks++; if (sig_o !== m_out) begin errors++; $display("FAIL rand_sig_o cyc=%0d got=%b exp=%b", cyc, sig_o, m_out); end
            checks++; if (rise_o !== m_rise) begin errors++; $display("FAIL rand_rise_o cyc=%0d got=%b exp=%b", cyc, rise_o, m_rise); end
            checks++; if (fall_o !== m_fall) begin errors++; $display("FAIL rand_fall_o cyc=%0d got=%b exp=%b", cyc, fall_o, m_fall); end
            checks++; if (evt_o !== m_evt) begin errors++; $display("FAIL rand_evt_o cyc=%0d got=%b exp=%b", cyc, evt_o, m_evt); end
            checks++; if (irq_o !== m_irq) begin errors++; $display("FAIL rand_irq_o cyc=%0d got=%b exp=%b", cyc, irq_o, m_irq); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_enable_pause();
        test_evt_clear();
        test_irq_mask();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_conditioner.md
Name: gpio_conditioner

Overview:
Parametrised N-channel input conditioner that replaces the per-pin synchroniser/debounce instances at the soc top level. Each channel has a synchroniser chain, a debounce counter, registered rise/fall pulses and a sticky event flag. The event flags are combined through a mask into one interrupt-style flag for the cpu gpi path. All channels share one clock and one enable.

Parameters:
N_CH, 8, number of independent channels (1..32)
SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2)
CLK_PERIOD_NS, 20, clock period in ns
DEBOUNCE_NS, 30_000_000, stable time required before the output changes
RESET_VAL, 0, per-channel debounced-output reset value, N_CH-bit vector

Ports:
clk  input  1  system clock, 50 MHz
resetn  input  1  asynchronous active-low reset
enable  input  1  debounce counters advance only while high
sig_i  input  N_CH  raw asynchronous inputs (switches/buttons)
evt_mask  input  N_CH  1 = channel contributes to irq_o
evt_clr  input  N_CH  write-1-to-clear for evt_o, sampled each cycle
sig_o  output  N_CH  debounced level
rise_o  output  N_CH  one-cycle pulse on debounced 0->1
fall_o  output  N_CH  one-cycle pulse on debounced 1->0
evt_o  output  N_CH  sticky event flags
irq_o  output  1  registered OR of (evt_o & evt_mask)

Behaviour:
- Reset is asynchronous and active-low. While resetn=0: sync chains load RESET_VAL; counters 0; sig_o=RESET_VAL; rise_o=fall_o=evt_o=0; irq_o=0.
- Derived constant DEB_CNT = DEBOUNCE_NS/CLK_PERIOD_NS, with a minimum of 1. Counter width is clog2(DEB_CNT+1).
- Sync: s = last stage of the SYNC_STAGES chain. The chain always runs, independent of enable.
- Debounce, per channel, each clock:
  - s == sig_o: counter <= 0.
  - s != sig_o and enable=0: counter holds.
  - s != sig_o, enable=1, counter < DEB_CNT-1: counter increments.
  - s != sig_o, enable=1, counter == DEB_CNT-1: sig_o <= s and counter <= 0.
- Any glitch that returns s to sig_o before the terminal count restarts the count from 0.
- Latency with enable held high: sig_o changes SYNC_STAGES+DEB_CNT clocks after a clean sig_i edge.
- rise_o/fall_o are registered in the same cycle that sig_o updates. They are high for exactly 1 cycle and are never both high.
- evt_o set source: rise_o. Clear source: evt_clr.
  - Set and clear in the same cycle: set wins.
  - Clear with no pending event: no effect.
- irq_o is registered one cycle after evt_o/evt_mask. A mask change affects irq_o on the next cycle.
- Channels are fully independent. Simultaneous edges on several channels are all captured.
- Reset mid-count discards the partial count. After release, no pulse or event is generated for RESET_VAL itself.

Optional Feature:
GPIO_COND_FALL_EVT_EN
- Defined: evt_o is also set by fall_o, so both edges are latched. Set-wins priority is unchanged.
- Undefined: only rise_o sets evt_o. fall_o is still output.

Decomposition:
- Package gpio_cond_pkg holds:
  - default CLK_PERIOD_NS and DEBOUNCE_NS constants
  - a function computing DEB_CNT with the minimum-of-1 clamp
  - a function computing the counter width
- Sub-module gpio_cond_channel: synchroniser, debounce counter, edge pulses and evt flag for one bit. It is instantiated N_CH times in a generate loop.
- The top level adds only the irq_o mask/OR register.

Test Plan:
Use CLK_PERIOD_NS=20, DEBOUNCE_NS=100 (DEB_CNT=5), SYNC_STAGES=2, N_CH=4, RESET_VAL=0.
1. sig_i[0] 0->1, held, enable=1 -> sig_o[0]=1 exactly 7 clocks later; rise_o[0] high for 1 cycle in that clock; evt_o[0]=1 thereafter.
2. sig_i[1] high for 3 clocks then low (glitch) -> sig_o[1], rise_o[1] and evt_o[1] stay 0; counter returns to 0.
3. Stable change on ch2 with enable low for 10 clocks mid-count -> sig_o[2] update delayed by exactly 10 clocks.
4. evt_clr[0] asserted in the same cycle as a new rise on ch0 -> evt_o[0] remains 1. A later lone evt_clr[0] -> evt_o[0]=0 next cycle.
5. evt_o=4'b0101, evt_mask=4'b0100 -> irq_o=1. Mask 4'b1010 -> irq_o=0 one cycle later.
6. resetn pulsed low mid-count on ch3 -> all outputs 0 immediately (async); no pulse after release with sig_i=0. With GPIO_COND_FALL_EVT_EN, a 1->0 on ch3 sets evt_o[3].
